mc_ctrl: RTL and testbench

Multicycle main control FSM for the MIPS-subset datapath. Decodes the instruction opcode, sequences fetch/decode/execute/memory/writeback states, and drives the datapath mux selects and write strobes. It supplies the 2-bit ALU operation class consumed by the ALU control decoder (aluop1/aluop0). Memory accesses use a ready handshake so slow memory can stall the sequence.

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control-side bundle between the multicycle main FSM and the MIPS-subset datapath.
// slave = controller (mc_ctrl), master = datapath / environment.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic [1:0] pcsource;
    logic       aluop1;
    logic       aluop0;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, zext, pcsource, aluop1, aluop0, instr_done, illegal, state
    );

    modport master (
        output opcode, zero, mem_ready,
        input  pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
               alusrca, alusrcb, zext, pcsource, aluop1, aluop0, instr_done, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle main control FSM for the MIPS-subset datapath (Moore decode, mem_ready stalls).
// Optional ori support is enabled by defining MC_CTRL_ORI_EN.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.slave   bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_RTEXEC = 4'd7;
    localparam logic [3:0] S_RTWB   = 4'd8;
    localparam logic [3:0] S_BEQEX  = 4'd9;
    localparam logic [3:0] S_JEX    = 4'd10;
`ifdef MC_CTRL_ORI_EN
    localparam logic [3:0] S_ORIEX  = 4'd11;
    localparam logic [3:0] S_ORIWB  = 4'd12;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next;

    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic       w_zext;
    logic [1:0] w_pcsource;
    logic [1:0] w_aluop;
    logic       w_instr_done;
    logic       w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     w_next = S_RTEXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
`ifdef MC_CTRL_ORI_EN
                    OP_ORI:       w_next = S_ORIEX;
`endif
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXEC: w_next = S_RTWB;
            S_RTWB:   w_next = S_FETCH;
            S_BEQEX:  w_next = S_FETCH;
            S_JEX:    w_next = S_FETCH;
`ifdef MC_CTRL_ORI_EN
            S_ORIEX:  w_next = S_ORIWB;
            S_ORIWB:  w_next = S_FETCH;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_zext        = 1'b0;
        w_pcsource    = 2'b00;
        w_aluop       = 2'b00;
        w_instr_done  = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                w_alusrcb = 2'b11;
                case (bus.opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: w_illegal = 1'b0;
`ifdef MC_CTRL_ORI_EN
                    OP_ORI:                               w_illegal = 1'b0;
`endif
                    default:                              w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite   = 1'b1;
                w_memtoreg   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite   = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = bus.mem_ready;
            end
            S_RTEXEC: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            S_RTWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca     = 1'b1;
                w_aluop       = 2'b01;
                w_pcsource    = 2'b01;
                w_pcwritecond = 1'b1;
                w_instr_done  = 1'b1;
            end
            S_JEX: begin
                w_pcsource   = 2'b10;
                w_pcwrite    = 1'b1;
                w_instr_done = 1'b1;
            end
`ifdef MC_CTRL_ORI_EN
            S_ORIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_zext    = 1'b1;
                w_aluop   = 2'b11;
            end
            S_ORIWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.pc_en      = w_pcwrite | (w_pcwritecond & bus.zero);
    assign bus.iord       = w_iord;
    assign bus.memread    = w_memread;
    assign bus.memwrite   = w_memwrite;
    assign bus.irwrite    = w_irwrite;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regdst     = w_regdst;
    assign bus.regwrite   = w_regwrite;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.zext       = w_zext;
    assign bus.pcsource   = w_pcsource;
    assign bus.aluop1     = w_aluop[1];
    assign bus.aluop0     = w_aluop[0];
    assign bus.instr_done = w_instr_done;
    assign bus.illegal    = w_illegal;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl plus hand sequences for latency, FETCH stall and async reset.
// Expectations follow MC_CTRL_ORI_EN the same way the design does.
module tb_mc_ctrl;
    logic clk;
    logic rst_n;
    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout, MSB first: pc_en iord memread memwrite irwrite memtoreg regdst
    // regwrite alusrca alusrcb[1:0] zext pcsource[1:0] aluop1 aluop0 instr_done illegal
    localparam logic [17:0] B_PCEN    = 18'd1 << 17;
    localparam logic [17:0] B_IORD    = 18'd1 << 16;
    localparam logic [17:0] B_MEMRD   = 18'd1 << 15;
    localparam logic [17:0] B_MEMWR   = 18'd1 << 14;
    localparam logic [17:0] B_IRW     = 18'd1 << 13;
    localparam logic [17:0] B_M2R     = 18'd1 << 12;
    localparam logic [17:0] B_RDST    = 18'd1 << 11;
    localparam logic [17:0] B_RW      = 18'd1 << 10;
    localparam logic [17:0] B_SRCA    = 18'd1 << 9;
    localparam logic [17:0] B_SRCB_4  = 18'd1 << 7;
    localparam logic [17:0] B_SRCB_IM = 18'd2 << 7;
    localparam logic [17:0] B_SRCB_SH = 18'd3 << 7;
    localparam logic [17:0] B_ZEXT    = 18'd1 << 6;
    localparam logic [17:0] B_PCS_OUT = 18'd1 << 4;
    localparam logic [17:0] B_PCS_J   = 18'd2 << 4;
    localparam logic [17:0] B_OP_SUB  = 18'd1 << 2;
    localparam logic [17:0] B_OP_FN   = 18'd2 << 2;
    localparam logic [17:0] B_OP_OR   = 18'd3 << 2;
    localparam logic [17:0] B_DONE    = 18'd1 << 1;
    localparam logic [17:0] B_ILL     = 18'd1;

    localparam logic [17:0] E_ZERO     = 18'd0;
    localparam logic [17:0] E_FETCH_W  = B_MEMRD | B_SRCB_4;
    localparam logic [17:0] E_FETCH_R  = B_PCEN | B_MEMRD | B_IRW | B_SRCB_4;
    localparam logic [17:0] E_DECODE   = B_SRCB_SH;
    localparam logic [17:0] E_DEC_ILL  = B_SRCB_SH | B_ILL;
    localparam logic [17:0] E_MEMADR   = B_SRCA | B_SRCB_IM;
    localparam logic [17:0] E_MEMRD    = B_MEMRD | B_IORD;
    localparam logic [17:0] E_MEMWB    = B_RW | B_M2R | B_DONE;
    localparam logic [17:0] E_MEMWR_W  = B_MEMWR | B_IORD;
    localparam logic [17:0] E_MEMWR_R  = B_MEMWR | B_IORD | B_DONE;
    localparam logic [17:0] E_RTEXEC   = B_SRCA | B_OP_FN;
    localparam logic [17:0] E_RTWB     = B_RW | B_RDST | B_DONE;
    localparam logic [17:0] E_BEQ_Z    = B_PCEN | B_SRCA | B_OP_SUB | B_PCS_OUT | B_DONE;
    localparam logic [17:0] E_BEQ_NZ   = B_SRCA | B_OP_SUB | B_PCS_OUT | B_DONE;
    localparam logic [17:0] E_JEX      = B_PCEN | B_PCS_J | B_DONE;
    localparam logic [17:0] E_ORIEX    = B_SRCA | B_SRCB_IM | B_ZEXT | B_OP_OR;
    localparam logic [17:0] E_ORIWB    = B_RW | B_DONE;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    logic [17:0] act_ctl;
    assign act_ctl = {bus.pc_en, bus.iord, bus.memread, bus.memwrite, bus.irwrite,
                      bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
                      bus.zext, bus.pcsource, bus.aluop1, bus.aluop0, bus.instr_done,
                      bus.illegal};

    task automatic add(input string name, input logic r, input logic [5:0] op,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [17:0] ctl);
        vec_t v;
        v.name = name; v.rst_n = r; v.op = op; v.zero = z; v.mr = mr; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Runs one instruction from FETCH and measures cycles up to instr_done/illegal inclusive.
    task automatic latency(input string name, input logic [5:0] op, input int exp);
        int  cnt;
        bit  seen;
        cnt = 0;
        seen = 1'b0;
        bus.opcode = op;
        bus.mem_ready = 1'b1;
        check({name, "_start_fetch"}, 32'(bus.state), 32'd1);
        for (int c = 0; c < 20 && !seen; c++) begin
            cnt++;
            if (bus.instr_done || bus.illegal) seen = 1'b1;
            else tick();
        end
        check({name, "_terminated"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(cnt), 32'(exp));
        tick();
    endtask

    initial begin
        int ir_cnt;
        int pc_cnt;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.opcode = OP_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        add("rst0", 0, OP_R, 0, 1, 4'd0, E_ZERO);
        add("rst1", 0, OP_R, 0, 1, 4'd0, E_ZERO);
        add("rst2", 0, OP_R, 0, 1, 4'd0, E_ZERO);
        add("idle", 1, OP_R, 0, 1, 4'd0, E_ZERO);
        add("r_fetch", 1, OP_R, 0, 1, 4'd1, E_FETCH_R);
        add("r_decode", 1, OP_R, 0, 1, 4'd2, E_DECODE);
        add("r_exec", 1, OP_R, 0, 1, 4'd7, E_RTEXEC);
        add("r_wb", 1, OP_R, 0, 1, 4'd8, E_RTWB);
        add("lw_fetch", 1, OP_LW, 0, 1, 4'd1, E_FETCH_R);
        add("lw_decode", 1, OP_LW, 0, 1, 4'd2, E_DECODE);
        add("lw_memadr", 1, OP_LW, 0, 1, 4'd3, E_MEMADR);
        add("lw_memrd_w1", 1, OP_LW, 0, 0, 4'd4, E_MEMRD);
        add("lw_memrd_w2", 1, OP_LW, 0, 0, 4'd4, E_MEMRD);
        add("lw_memrd_ok", 1, OP_LW, 0, 1, 4'd4, E_MEMRD);
        add("lw_memwb", 1, OP_LW, 0, 1, 4'd5, E_MEMWB);
        add("sw_fetch", 1, OP_SW, 0, 1, 4'd1, E_FETCH_R);
        add("sw_decode", 1, OP_SW, 0, 1, 4'd2, E_DECODE);
        add("sw_memadr", 1, OP_SW, 0, 1, 4'd3, E_MEMADR);
        add("sw_memwr", 1, OP_SW, 0, 1, 4'd6, E_MEMWR_R);
        add("beq1_fetch", 1, OP_BEQ, 1, 1, 4'd1, E_FETCH_R);
        add("beq1_decode", 1, OP_BEQ, 1, 1, 4'd2, E_DECODE);
        add("beq1_ex", 1, OP_BEQ, 1, 1, 4'd9, E_BEQ_Z);
        add("beq0_fetch", 1, OP_BEQ, 0, 1, 4'd1, E_FETCH_R);
        add("beq0_decode", 1, OP_BEQ, 0, 1, 4'd2, E_DECODE);
        add("beq0_ex", 1, OP_BEQ, 0, 1, 4'd9, E_BEQ_NZ);
        add("j_fetch", 1, OP_J, 0, 1, 4'd1, E_FETCH_R);
        add("j_decode", 1, OP_J, 0, 1, 4'd2, E_DECODE);
        add("j_ex", 1, OP_J, 0, 1, 4'd10, E_JEX);
        for (int i = 0; i < 4; i++) add("stall_fetch", 1, OP_BAD, 0, 0, 4'd1, E_FETCH_W);
        add("stall_fetch_ok", 1, OP_BAD, 0, 1, 4'd1, E_FETCH_R);
        add("bad_decode", 1, OP_BAD, 0, 1, 4'd2, E_DEC_ILL);
        add("ori_fetch", 1, OP_ORI, 0, 1, 4'd1, E_FETCH_R);
`ifdef MC_CTRL_ORI_EN
        add("ori_decode", 1, OP_ORI, 0, 1, 4'd2, E_DECODE);
        add("ori_ex", 1, OP_ORI, 0, 1, 4'd11, E_ORIEX);
        add("ori_wb", 1, OP_ORI, 0, 1, 4'd12, E_ORIWB);
`else
        add("ori_decode_ill", 1, OP_ORI, 0, 1, 4'd2, E_DEC_ILL);
`endif
        add("sw2_fetch", 1, OP_SW, 0, 1, 4'd1, E_FETCH_R);
        add("sw2_decode", 1, OP_SW, 0, 1, 4'd2, E_DECODE);
        add("sw2_memadr", 1, OP_SW, 0, 0, 4'd3, E_MEMADR);
        add("sw2_memwr_w", 1, OP_SW, 0, 0, 4'd6, E_MEMWR_W);
        add("sw2_abort", 0, OP_SW, 0, 0, 4'd0, E_ZERO);
        add("sw2_release", 1, OP_SW, 0, 1, 4'd0, E_ZERO);
        add("sw2_refetch", 1, OP_SW, 0, 1, 4'd1, E_FETCH_R);

        #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            bus.opcode = vecs[i].op;
            bus.zero = vecs[i].zero;
            bus.mem_ready = vecs[i].mr;
            #1;
            check({vecs[i].name, "_state"}, 32'(bus.state), 32'(vecs[i].st));
            check({vecs[i].name, "_ctl"}, 32'(act_ctl), 32'(vecs[i].ctl));
            tick();
        end

        do_reset();
        latency("lat_lw", OP_LW, 5);
        latency("lat_sw", OP_SW, 4);
        latency("lat_r", OP_R, 4);
        latency("lat_beq", OP_BEQ, 3);
        latency("lat_j", OP_J, 3);
        latency("lat_bad", OP_BAD, 2);
`ifdef MC_CTRL_ORI_EN
        latency("lat_ori", OP_ORI, 4);
`else
        latency("lat_ori_ill", OP_ORI, 2);
`endif

        // irwrite and pc_en must fire once, only on the cycle mem_ready returns.
        ir_cnt = 0;
        pc_cnt = 0;
        bus.opcode = OP_R;
        for (int c = 0; c < 5; c++) begin
            bus.mem_ready = (c == 4);
            #1;
            ir_cnt += int'(bus.irwrite);
            pc_cnt += int'(bus.pc_en);
            tick();
        end
        check("stall_irwrite_count", 32'(ir_cnt), 32'd1);
        check("stall_pc_en_count", 32'(pc_cnt), 32'd1);
        check("stall_then_decode", 32'(bus.state), 32'd2);

        // Reset drop mid-MEMWR, checked before any clock edge.
        do_reset();
        bus.opcode = OP_SW;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        check("async_memwr_before", 32'(bus.memwrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_memwr_drop", 32'(bus.memwrite), 32'd0);
        check("async_state_idle", 32'(bus.state), 32'd0);
        check("async_ctl_zero", 32'(act_ctl), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("async_release_idle", 32'(bus.state), 32'd0);
        tick();
        check("async_refetch", 32'(bus.state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
